// File: rtl/tick_task_scheduler_if.sv
// Scheduler bus: channel config, grant/done handshake
// and status flags between the scheduler and its consumers.
interface tick_task_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int PW  = 16
);
  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic           tick_o;
  logic [NCH-1:0] grant_o;
  logic [CW-1:0]  grant_idx_o;
  logic           done_i;
  logic [NCH-1:0] pending_o;
  logic [NCH-1:0] overrun_o;
  logic           overrun_clr;

  modport master (
    output cfg_we, cfg_ch, cfg_period,
    output done_i, overrun_clr,
    input  tick_o, grant_o, grant_idx_o,
    input  pending_o, overrun_o
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period,
    input  done_i, overrun_clr,
    output tick_o, grant_o, grant_idx_o,
    output pending_o, overrun_o
  );
endinterface

// File: rtl/tick_task_scheduler.sv
// Shared-timebase periodic task scheduler: one prescaler
// tick, NCH tick counters, round-robin grant/done arbiter.
module tick_task_scheduler #(
  parameter int NCH      = 4,
  parameter int CW       = 2,
  parameter int PRESCALE = 1000,
  parameter int PW       = 16
) (
  input logic clk_i,
  input logic reset,
  tick_task_scheduler_if.slave bus
);
  localparam int PCW = $clog2(PRESCALE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [PCW-1:0] pre;
  logic           tick;
  logic [PW-1:0]  per [NCH];
  logic [PW-1:0]  cnt [NCH];
  logic [NCH-1:0] pend;
  logic [NCH-1:0] ovr;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  gidx;
  logic [CW-1:0]  rr;

  logic [NCH-1:0] hit;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] gclr;
  logic [NCH-1:0] pend_n;
  logic [NCH-1:0] ovr_n;
  logic [CW-1:0]  sel;
  logic [CW:0]    slot;
  logic           any;

  assign bus.tick_o      = tick;
  assign bus.grant_o     = grant;
  assign bus.grant_idx_o = gidx;
  assign bus.pending_o   = pend;
  assign bus.overrun_o   = ovr;

  // Prescaler: tick pulses the cycle after the wrap value
  always_ff @(posedge clk_i) begin
    if (reset) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pre == PCW'(PRESCALE - 1));
      if (pre == PCW'(PRESCALE - 1))
        pre <= '0;
      else
        pre <= pre + 1'b1;
    end
  end

  // Per-channel config hits and expiries; a config write wins
  always_comb begin
    hit    = '0;
    expire = '0;
    for (int c = 0; c < NCH; c++) begin
      hit[c]    = bus.cfg_we && (bus.cfg_ch == CW'(c));
      expire[c] = tick && (per[c] != '0) &&
                  (cnt[c] == PW'(1)) && !hit[c];
    end
  end

  // First pending channel after the rr pointer, wrapping
  always_comb begin
    any  = |pend;
    sel  = '0;
    slot = '0;
    for (int i = NCH; i >= 1; i--) begin
      slot = {1'b0, rr} + (CW+1)'(i);
      if (slot >= (CW+1)'(NCH))
        slot = slot - (CW+1)'(NCH);
      if (pend[slot[CW-1:0]])
        sel = slot[CW-1:0];
    end
  end

  // Pending/overrun next state; expiry beats the grant-clear
  always_comb begin
    gclr   = '0;
    pend_n = pend;
    ovr_n  = bus.overrun_clr ? '0 : ovr;
    if (state == IDLE && any)
      gclr = NCH'(1) << sel;
    for (int c = 0; c < NCH; c++) begin
      if (expire[c] && pend[c] && !gclr[c])
        ovr_n[c] = 1'b1;
      if (hit[c])
        pend_n[c] = 1'b0;
      else if (expire[c])
        pend_n[c] = 1'b1;
      else if (gclr[c])
        pend_n[c] = 1'b0;
    end
  end

  // Channel periods, tick counters and status flags
  always_ff @(posedge clk_i) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        per[c] <= '0;
        cnt[c] <= '0;
      end
      pend <= '0;
      ovr  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (hit[c]) begin
          per[c] <= bus.cfg_period;
          cnt[c] <= bus.cfg_period;
        end else if (tick && per[c] != '0) begin
          if (cnt[c] == PW'(1))
            cnt[c] <= per[c];
          else
            cnt[c] <= cnt[c] - 1'b1;
        end
      end
      pend <= pend_n;
      ovr  <= ovr_n;
    end
  end

  // Grant FSM: IDLE picks a channel, BUSY waits for done
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      rr    <= CW'(NCH - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant <= NCH'(1) << sel;
            gidx  <= sel;
            rr    <= sel;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.done_i) begin
            grant <= '0;
            gidx  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tick_task_scheduler.sv
// Bench for tick_task_scheduler: vector table, directed
// corner sequences and random traffic against a model.
module tb_tick_task_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int PRE = 4;
  localparam int PW  = 8;

  logic clk_i = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  tick_task_scheduler_if #(
    .NCH(NCH), .CW(CW), .PW(PW)
  ) bus ();

  tick_task_scheduler #(
    .NCH(NCH), .CW(CW), .PRESCALE(PRE), .PW(PW)
  ) dut (
    .clk_i (clk_i),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: ticks from an edge count, channel
  // deadlines as remaining-tick integers, grant as an index.
  int m_per [NCH];
  int m_rem [NCH];
  bit m_pend [NCH];
  bit m_ovr [NCH];
  int m_gnt;
  int m_rr;
  int m_k;
  bit m_tick;

  task automatic model_step();
    bit tk;
    bit hit [NCH];
    bit ex [NCH];
    bit gc [NCH];
    int sel;
    int c;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = 0; m_rem[i] = 0;
        m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_gnt = -1; m_rr = NCH - 1;
      m_k = 0; m_tick = 0;
      return;
    end
    tk = m_tick;
    sel = -1;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);
      ex[i] = tk && m_per[i] != 0 && m_rem[i] == 1
              && !hit[i];
      gc[i] = 0;
    end
    if (m_gnt < 0) begin
      for (int off = 1; off <= NCH; off++) begin
        c = (m_rr + off) % NCH;
        if (sel < 0 && m_pend[c]) sel = c;
      end
      if (sel >= 0) begin
        gc[sel] = 1; m_gnt = sel; m_rr = sel;
      end
    end else if (bus.done_i) begin
      m_gnt = -1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ex[i] && m_pend[i] && !gc[i]) m_ovr[i] = 1;
      else if (bus.overrun_clr) m_ovr[i] = 0;
      if (hit[i]) m_pend[i] = 0;
      else if (ex[i]) m_pend[i] = 1;
      else if (gc[i]) m_pend[i] = 0;
      if (hit[i]) begin
        m_per[i] = int'(bus.cfg_period);
        m_rem[i] = m_per[i];
      end else if (tk && m_per[i] != 0) begin
        m_rem[i] = (m_rem[i] == 1) ? m_per[i]
                                   : m_rem[i] - 1;
      end
    end
    m_k++;
    m_tick = (m_k % PRE == 0);
  endtask

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0h exp=%0h",
               nm, $time, act, exp);
    end
  endtask

  function automatic int vec(bit v [NCH]);
    int r = 0;
    for (int i = 0; i < NCH; i++) r |= int'(v[i]) << i;
    return r;
  endfunction

  task automatic model_chk();
    int eg;
    eg = (m_gnt < 0) ? 0 : (1 << m_gnt);
    chk("m_tick", int'(bus.tick_o), int'(m_tick));
    chk("m_grant", int'(bus.grant_o), eg);
    chk("m_pend", int'(bus.pending_o), vec(m_pend));
    chk("m_ovr", int'(bus.overrun_o), vec(m_ovr));
    if (m_gnt >= 0)
      chk("m_gidx", int'(bus.grant_idx_o), m_gnt);
  endtask

  // One clock: model follows the edge, outputs sampled +1
  task automatic cyc(bit mchk = 1'b1);
    @(posedge clk_i);
    model_step();
    #1;
    if (mchk) model_chk();
  endtask

  task automatic idle_in();
    bus.cfg_we = 0; bus.cfg_ch = '0;
    bus.cfg_period = '0; bus.done_i = 0;
    bus.overrun_clr = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  typedef struct {
    bit       we;
    int       ch;
    int       per;
    bit       done;
    bit       clr;
    bit       tick;
    int       grant;
    int       pend;
    int       ovr;
  } vec_t;

  vec_t tbl [25];

  task automatic set_row(int i, bit we, int ch, int per,
                         bit dn, bit cl, bit tk, int g,
                         int p, int o);
    tbl[i].we = we; tbl[i].ch = ch; tbl[i].per = per;
    tbl[i].done = dn; tbl[i].clr = cl; tbl[i].tick = tk;
    tbl[i].grant = g; tbl[i].pend = p; tbl[i].ovr = o;
  endtask

  int q [$];
  int prev;
  bit ok;

  initial begin
    idle_in();
    // ch0 P=1: service, withhold done, overrun, clear,
    // reconfigure to P=0 while granted and pending.
    for (int i = 0; i < 25; i++)
      set_row(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_row(0,  1, 0, 1, 0, 0, 0, 0, 0, 0);
    set_row(3,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    set_row(4,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_row(5,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_row(6,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    set_row(7,  0, 0, 0, 0, 0, 1, 0, 0, 0);
    set_row(8,  0, 0, 0, 0, 0, 0, 0, 1, 0);
    set_row(9,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_row(10, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_row(11, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_row(12, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_row(13, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_row(14, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_row(15, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    set_row(16, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    set_row(17, 0, 0, 0, 1, 0, 0, 0, 1, 1);
    set_row(18, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    set_row(19, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    set_row(20, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    set_row(21, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    set_row(22, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    set_row(23, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    set_row(24, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    do_reset();
    chk("rst_tick", int'(bus.tick_o), 0);
    chk("rst_grant", int'(bus.grant_o), 0);
    chk("rst_pend", int'(bus.pending_o), 0);
    chk("rst_ovr", int'(bus.overrun_o), 0);

    for (int i = 0; i < 25; i++) begin
      bus.cfg_we = tbl[i].we;
      bus.cfg_ch = CW'(tbl[i].ch);
      bus.cfg_period = PW'(tbl[i].per);
      bus.done_i = tbl[i].done;
      bus.overrun_clr = tbl[i].clr;
      cyc(1'b0);
      chk($sformatf("row%0d_tick", i),
          int'(bus.tick_o), int'(tbl[i].tick));
      chk($sformatf("row%0d_grant", i),
          int'(bus.grant_o), tbl[i].grant);
      chk($sformatf("row%0d_pend", i),
          int'(bus.pending_o), tbl[i].pend);
      chk($sformatf("row%0d_ovr", i),
          int'(bus.overrun_o), tbl[i].ovr);
    end
    idle_in();

    // Round-robin order with immediate done
    do_reset();
    bus.cfg_we = 1; bus.cfg_period = PW'(1);
    bus.cfg_ch = 2'd0; cyc();
    bus.cfg_ch = 2'd2; cyc();
    bus.cfg_ch = 2'd3; cyc();
    bus.cfg_we = 0; bus.done_i = 1;
    q = {}; prev = 0;
    for (int i = 0; i < 40 && q.size() < 4; i++) begin
      cyc();
      if (bus.grant_o != 0 && prev == 0)
        q.push_back(int'(bus.grant_idx_o));
      prev = int'(bus.grant_o);
    end
    chk("rr_count", q.size(), 4);
    if (q.size() == 4) begin
      chk("rr_0", q[0], 0);
      chk("rr_1", q[1], 2);
      chk("rr_2", q[2], 3);
      chk("rr_3", q[3], 0);
    end
    idle_in();

    // Reset in the middle of a grant on ch2
    do_reset();
    bus.cfg_we = 1; bus.cfg_ch = 2'd2;
    bus.cfg_period = PW'(1);
    cyc();
    idle_in();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (bus.grant_o == 4'b0100) ok = 1;
    end
    chk("rg_seen", int'(ok), 1);
    reset = 1;
    cyc();
    chk("rg_drop", int'(bus.grant_o), 0);
    reset = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("rg_pend", int'(bus.pending_o), 0);
    chk("rg_grant", int'(bus.grant_o), 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      bus.cfg_we = ($urandom_range(0, 11) == 0);
      bus.cfg_ch = CW'($urandom_range(0, NCH - 1));
      bus.cfg_period = ($urandom_range(0, 9) == 0)
                       ? PW'(0)
                       : PW'($urandom_range(1, 3));
      bus.done_i = ($urandom_range(0, 2) == 0);
      bus.overrun_clr = ($urandom_range(0, 24) == 0);
      cyc();
    end
    reset = 0;
    idle_in();
    cyc();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
